// File: rtl/chacha_qr_sched_if.sv
// chacha_qr_sched_if
//   Bundles the block-level handshakes and the quarter-round core operand and
//   result buses of chacha_qr_sched.
//   in_valid/in_ready/in_state    : 512-bit initial state stream (word i = bits [32i+31:32i])
//   out_valid/out_ready/out_block : 512-bit keystream block stream, same packing
//   qr_a..qr_d                    : operands presented to the external chacha_qr core
//   qr_a_prim..qr_d_prim          : results returned by the chacha_qr core
// Modports:
//   slave  : the scheduler itself
//   master : the surrounding logic (state producer, keystream consumer, QR core)
interface chacha_qr_sched_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic [31:0]  qr_a, qr_b, qr_c, qr_d;
  logic [31:0]  qr_a_prim, qr_b_prim, qr_c_prim, qr_d_prim;

  modport slave (
    input  in_valid, in_state, out_ready,
    input  qr_a_prim, qr_b_prim, qr_c_prim, qr_d_prim,
    output in_ready, out_valid, out_block,
    output qr_a, qr_b, qr_c, qr_d
  );

  modport master (
    output in_valid, in_state, out_ready,
    output qr_a_prim, qr_b_prim, qr_c_prim, qr_d_prim,
    input  in_ready, out_valid, out_block,
    input  qr_a, qr_b, qr_c, qr_d
  );
endinterface

// File: rtl/chacha_qr_sched.sv
// chacha_qr_sched
//   Computes one ChaCha block by time-multiplexing a single external chacha_qr
//   quarter-round core. A 16-word state is loaded, 8*DOUBLE_ROUNDS quarter
//   rounds are issued in column/diagonal order with results written back to an
//   internal state file, then the feed-forward addition produces the 512-bit
//   keystream block on a valid/ready output.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any block in flight
//   bus   : chacha_qr_sched_if.slave (input/output streams, QR core buses)
// Parameters:
//   DOUBLE_ROUNDS : 1..15 double rounds (10 = ChaCha20)
//   QR_LAT        : 1..4 cycles of chacha_qr core latency
// Optional build macro CHACHA_SCHED_CNT_EN adds:
//   blocks_done : wrapping count of output handshakes
//   busy_cycles : saturating count of cycles spent outside IDLE and DONE
module chacha_qr_sched #(
  parameter int DOUBLE_ROUNDS = 10,
  parameter int QR_LAT        = 1
) (
  input  logic              clk,
  input  logic              reset,
  chacha_qr_sched_if.slave  bus
`ifdef CHACHA_SCHED_CNT_EN
  ,
  output logic [31:0]       blocks_done,
  output logic [31:0]       busy_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, FINAL, DONE} state_t;

  localparam int             NQR       = 8 * DOUBLE_ROUNDS;
  localparam logic [6:0]     LAST_QR   = 7'(NQR - 1);
  // Only meaningful when QR_LAT > 1; WAIT is never entered otherwise.
  localparam logic [1:0]     WAIT_LAST = 2'(QR_LAT - 2);

  state_t       state_q, state_d;
  logic [31:0]  st_q   [16];
  logic [31:0]  init_q [16];
  logic [31:0]  st_wb  [16];
  logic [31:0]  in_w   [16];
  logic [6:0]   qr_idx_q;
  logic [1:0]   wait_cnt_q;
  logic [31:0]  qr_a_q, qr_b_q, qr_c_q, qr_d_q;
  logic [511:0] out_block_q;
  logic [15:0]  sel_cur, sel_nxt;

  // Word indices {a,b,c,d} for the QR slot within a double round.
  function automatic logic [15:0] qr_sel(input logic [2:0] s);
    unique case (s)
      3'd0:    return {4'd0, 4'd4, 4'd8,  4'd12};
      3'd1:    return {4'd1, 4'd5, 4'd9,  4'd13};
      3'd2:    return {4'd2, 4'd6, 4'd10, 4'd14};
      3'd3:    return {4'd3, 4'd7, 4'd11, 4'd15};
      3'd4:    return {4'd0, 4'd5, 4'd10, 4'd15};
      3'd5:    return {4'd1, 4'd6, 4'd11, 4'd12};
      3'd6:    return {4'd2, 4'd7, 4'd8,  4'd13};
      default: return {4'd3, 4'd4, 4'd9,  4'd14};
    endcase
  endfunction

  // Feed-forward word add, modulo 2^32.
  function automatic logic [31:0] add_mod32(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  assign sel_cur = qr_sel(qr_idx_q[2:0]);
  assign sel_nxt = qr_sel(qr_idx_q[2:0] + 3'd1);

  always_comb begin
    for (int i = 0; i < 16; i++) in_w[i] = bus.in_state[32*i +: 32];
  end

  // State file as it will look after the CAPT write-back. The next QR's
  // operands are taken from here so an index shared between consecutive QRs
  // (e.g. word 15 from column 3 into diagonal 0) sees the fresh value.
  always_comb begin
    st_wb = st_q;
    st_wb[sel_cur[15:12]] = bus.qr_a_prim;
    st_wb[sel_cur[11:8]]  = bus.qr_b_prim;
    st_wb[sel_cur[7:4]]   = bus.qr_c_prim;
    st_wb[sel_cur[3:0]]   = bus.qr_d_prim;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = ISSUE;
      end
      ISSUE: state_d = (QR_LAT > 1) ? WAIT : CAPT;
      WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = CAPT;
      CAPT:  state_d = (qr_idx_q == LAST_QR) ? FINAL : ISSUE;
      FINAL: state_d = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are loaded on the edge that enters ISSUE and held until the
  // edge that leaves CAPT, so the core sees them stable for the whole QR.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= '{default: '0};
      init_q      <= '{default: '0};
      qr_idx_q    <= '0;
      wait_cnt_q  <= '0;
      qr_a_q      <= '0;
      qr_b_q      <= '0;
      qr_c_q      <= '0;
      qr_d_q      <= '0;
      out_block_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          st_q     <= in_w;
          init_q   <= in_w;
          qr_idx_q <= '0;
          // First QR is column 0: words 0, 4, 8, 12.
          qr_a_q   <= in_w[0];
          qr_b_q   <= in_w[4];
          qr_c_q   <= in_w[8];
          qr_d_q   <= in_w[12];
        end
        ISSUE: wait_cnt_q <= '0;
        WAIT:  wait_cnt_q <= wait_cnt_q + 2'd1;
        CAPT: begin
          st_q <= st_wb;
          if (qr_idx_q != LAST_QR) begin
            qr_idx_q <= qr_idx_q + 7'd1;
            qr_a_q   <= st_wb[sel_nxt[15:12]];
            qr_b_q   <= st_wb[sel_nxt[11:8]];
            qr_c_q   <= st_wb[sel_nxt[7:4]];
            qr_d_q   <= st_wb[sel_nxt[3:0]];
          end
        end
        FINAL: begin
          for (int i = 0; i < 16; i++)
            out_block_q[32*i +: 32] <= add_mod32(st_q[i], init_q[i]);
        end
        default: ;
      endcase
    end
  end

  assign bus.qr_a      = qr_a_q;
  assign bus.qr_b      = qr_b_q;
  assign bus.qr_c      = qr_c_q;
  assign bus.qr_d      = qr_d_q;
  assign bus.out_block = out_block_q;

`ifdef CHACHA_SCHED_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      blocks_done <= '0;
      busy_cycles <= '0;
    end else begin
      if (state_q == DONE && bus.out_ready) blocks_done <= blocks_done + 32'd1;
      if (state_q != IDLE && state_q != DONE) busy_cycles <= sat_inc32(busy_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_chacha_qr_sched.sv
module tb_chacha_qr_sched;
  localparam int DR = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chacha_qr_sched_if ifa ();
  chacha_qr_sched_if ifb ();

`ifdef CHACHA_SCHED_CNT_EN
  logic [31:0] bd1, bc1, bd3, bc3;
`endif

  chacha_qr_sched #(.DOUBLE_ROUNDS(DR), .QR_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(ifa)
`ifdef CHACHA_SCHED_CNT_EN
    , .blocks_done(bd1), .busy_cycles(bc1)
`endif
  );

  chacha_qr_sched #(.DOUBLE_ROUNDS(DR), .QR_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(ifb)
`ifdef CHACHA_SCHED_CNT_EN
    , .blocks_done(bd3), .busy_cycles(bc3)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ChaCha quarter round, plain RFC 7539 form.
  function automatic logic [127:0] qr_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    a += b; d ^= a; d = {d[15:0], d[31:16]};
    c += d; b ^= c; b = {b[19:0], b[31:20]};
    a += b; d ^= a; d = {d[23:0], d[31:24]};
    c += d; b ^= c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Behavioural chacha_qr cores: latency 1 for dut1, latency 3 for dut3.
  logic [127:0] core1_q;
  logic [127:0] core3_q [3];
  always @(posedge clk) begin
    if (reset) begin
      core1_q <= '0;
      for (int k = 0; k < 3; k++) core3_q[k] <= '0;
    end else begin
      core1_q    <= qr_f(ifa.qr_a, ifa.qr_b, ifa.qr_c, ifa.qr_d);
      core3_q[0] <= qr_f(ifb.qr_a, ifb.qr_b, ifb.qr_c, ifb.qr_d);
      core3_q[1] <= core3_q[0];
      core3_q[2] <= core3_q[1];
    end
  end
  assign {ifa.qr_a_prim, ifa.qr_b_prim, ifa.qr_c_prim, ifa.qr_d_prim} = core1_q;
  assign {ifb.qr_a_prim, ifb.qr_b_prim, ifb.qr_c_prim, ifb.qr_d_prim} = core3_q[2];

  // Word index of operand pos (0..3) of quarter round k: columns then diagonals.
  function automatic int qidx(input int k, input int pos);
    int j;
    j = k % 4;
    if ((k % 8) < 4) return j + 4 * pos;
    return 4 * pos + (j + pos) % 4;
  endfunction

  function automatic logic [511:0] run_qrs(input logic [511:0] st, input int n);
    logic [31:0]  x [16];
    logic [127:0] r;
    logic [511:0] o;
    for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
    for (int k = 0; k < n; k++) begin
      r = qr_f(x[qidx(k, 0)], x[qidx(k, 1)], x[qidx(k, 2)], x[qidx(k, 3)]);
      x[qidx(k, 0)] = r[127:96];
      x[qidx(k, 1)] = r[95:64];
      x[qidx(k, 2)] = r[63:32];
      x[qidx(k, 3)] = r[31:0];
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i];
    return o;
  endfunction

  function automatic logic [127:0] exp_ops(input logic [511:0] st, input int k);
    logic [511:0] s;
    s = run_qrs(st, k);
    return {s[32*qidx(k, 0) +: 32], s[32*qidx(k, 1) +: 32],
            s[32*qidx(k, 2) +: 32], s[32*qidx(k, 3) +: 32]};
  endfunction

  function automatic logic [511:0] ref_block(input logic [511:0] st);
    logic [511:0] s, o;
    s = run_qrs(st, 8 * DR);
    for (int i = 0; i < 16; i++) o[32*i +: 32] = s[32*i +: 32] + st[32*i +: 32];
    return o;
  endfunction

  function automatic logic get_ir(input int w);
    return (w != 0) ? ifb.in_ready : ifa.in_ready;
  endfunction
  function automatic logic get_ov(input int w);
    return (w != 0) ? ifb.out_valid : ifa.out_valid;
  endfunction
  function automatic logic [511:0] get_ob(input int w);
    return (w != 0) ? ifb.out_block : ifa.out_block;
  endfunction
  function automatic logic [127:0] get_ops(input int w);
    return (w != 0) ? {ifb.qr_a, ifb.qr_b, ifb.qr_c, ifb.qr_d}
                    : {ifa.qr_a, ifa.qr_b, ifa.qr_c, ifa.qr_d};
  endfunction

  task automatic drv_iv(input int w, input logic v);
    if (w != 0) ifb.in_valid = v; else ifa.in_valid = v;
  endtask
  task automatic drv_or(input int w, input logic v);
    if (w != 0) ifb.out_ready = v; else ifa.out_ready = v;
  endtask
  task automatic set_state(input logic [511:0] st);
    ifa.in_state = st;
    ifb.in_state = st;
  endtask

  task automatic check_reset_vals(input int w);
    check("rst_in_ready",  512'(get_ir(w)),  512'(1));
    check("rst_out_valid", 512'(get_ov(w)),  512'(0));
    check("rst_out_block", get_ob(w),        512'(0));
    check("rst_qr_ops",    512'(get_ops(w)), 512'(0));
  endtask

  // One block: accept, watch operands every cycle, measure latency counting
  // the accepting edge as edge 1, optionally stall the consumer, handshake.
  task automatic run_block(input int w, input logic [511:0] st, input int hold,
                           input bit pulse, output logic [511:0] res, output int edges);
    int lat;
    lat = (w != 0) ? 3 : 1;
    check("idle_in_ready", 512'(get_ir(w)), 512'(1));
    set_state(st);
    drv_iv(w, 1'b1);
    @(posedge clk); #1;
    drv_iv(w, 1'b0);
    edges = 1;
    while (!get_ov(w) && edges < 400) begin
      if (edges <= 8 * DR * (lat + 1))
        check("qr_operands", 512'(get_ops(w)), 512'(exp_ops(st, (edges - 1) / (lat + 1))));
      if (pulse && edges >= 40 && edges < 43) begin
        check("busy_in_ready", 512'(get_ir(w)), 512'(0));
        set_state(~st);
        drv_iv(w, 1'b1);
      end else begin
        set_state(st);
        drv_iv(w, 1'b0);
      end
      @(posedge clk); #1;
      edges++;
    end
    drv_iv(w, 1'b0);
    set_state(st);
    res = get_ob(w);
    check("out_valid_up", 512'(get_ov(w)), 512'(1));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 512'(get_ov(w)), 512'(1));
      check("hold_out_block", get_ob(w), res);
      check("hold_in_ready",  512'(get_ir(w)), 512'(0));
    end
    drv_or(w, 1'b1);
    @(posedge clk); #1;
    drv_or(w, 1'b0);
    check("post_hs_out_valid", 512'(get_ov(w)), 512'(0));
    check("post_hs_in_ready",  512'(get_ir(w)), 512'(1));
    check("post_hs_out_block", get_ob(w), res);
  endtask

  logic [511:0] rfc, rfc_exp, res, st;
  logic [31:0]  rfc_w [16];
  int           edges;
  logic         seen;

  initial begin
    rfc_w = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
              32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
              32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
              32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    for (int i = 0; i < 16; i++) rfc[32*i +: 32] = rfc_w[i];
    rfc_exp = ref_block(rfc);

    reset = 1'b1;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
    set_state('0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals(0);
    check_reset_vals(1);

`ifdef CHACHA_SCHED_CNT_EN
    check("cnt_rst_blocks", 512'(bd1), 512'(0));
    check("cnt_rst_busy",   512'(bc1), 512'(0));
    for (int b = 0; b < 3; b++) begin
      run_block(0, rfc, 0, 1'b0, res, edges);
      check("cnt_run_block", res, rfc_exp);
    end
    check("cnt_blocks_done", 512'(bd1), 512'(3));
    check("cnt_busy_cycles", 512'(bc1), 512'(3 * 161));
`endif

    // Known-answer block with a 20-cycle consumer stall.
    run_block(0, rfc, 20, 1'b0, res, edges);
    check("rfc_latency", 512'(edges), 512'(162));
    check("rfc_word0",  512'(res[31:0]),    512'(32'he4e7f110));
    check("rfc_word1",  512'(res[63:32]),   512'(32'h15593bd1));
    check("rfc_word15", 512'(res[511:480]), 512'(32'h4e3c50a2));
    check("rfc_block",  res, rfc_exp);

    // Abort at QR 37 with a one-cycle reset.
    set_state(rfc);
    drv_iv(0, 1'b1);
    @(posedge clk); #1;
    drv_iv(0, 1'b0);
    repeat (74) @(posedge clk);
    #1;
    check("qr37_operands", 512'(get_ops(0)), 512'(exp_ops(rfc, 37)));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals(0);
    seen = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (ifa.out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 512'(seen), 512'(0));
    run_block(0, rfc, 0, 1'b0, res, edges);
    check("rerun_latency", 512'(edges), 512'(162));
    check("rerun_block", res, rfc_exp);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) st[32*i +: 32] = $urandom();
      run_block(0, st, $urandom_range(0, 4), 1'b0, res, edges);
      check("rand_block_lat1", res, ref_block(st));
    end

    // QR_LAT=3 instance, with in_valid and a different in_state pulsed mid-run.
    run_block(1, rfc, 0, 1'b1, res, edges);
    check("lat3_latency", 512'(edges), 512'(322));
    check("lat3_word0", 512'(res[31:0]), 512'(32'he4e7f110));
    check("lat3_block", res, rfc_exp);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) st[32*i +: 32] = $urandom();
      run_block(1, st, $urandom_range(0, 4), 1'b0, res, edges);
      check("rand_block_lat3", res, ref_block(st));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chacha_qr_sched.md
Name: chacha_qr_sched

Overview:
Sequencer that computes one full ChaCha block by time-multiplexing a single external chacha_qr quarter-round core.
- Loads a 16-word input state.
- Issues 8*DOUBLE_ROUNDS quarter-rounds in column/diagonal order, writing results back to an internal 16x32 state file.
- Performs the final feed-forward addition and presents the 512-bit keystream block on a valid/ready output.
- Sits between the key/nonce/counter setup logic and the keystream consumer. The chacha_qr instance is placed beside it at top level.

Parameters:
DOUBLE_ROUNDS, 10, number of double rounds (10 gives ChaCha20); legal range 1..15
QR_LAT, 1, clock cycles from qr_a..qr_d being presented to qr_a_prim..qr_d_prim being valid; legal range 1..4

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_state is valid
in_ready  output  1  scheduler idle, can accept a block
in_state  input  512  initial state; word i = bits [32i+31:32i]
out_valid  output  1  out_block is valid
out_ready  input  1  consumer accepts out_block
out_block  output  512  keystream block, same word packing as in_state
qr_a, qr_b, qr_c, qr_d  output  32 each  operands to the quarter-round core
qr_a_prim, qr_b_prim, qr_c_prim, qr_d_prim  input  32 each  results from the quarter-round core

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - in_ready=1 on the first cycle after reset deasserts.
  - out_valid=0, out_block=0, qr_a..qr_d=0.
  - State file, saved initial state, QR index and wait counter all 0.
  - FSM goes to IDLE.
- FSM states: IDLE, ISSUE, WAIT, CAPT, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready at an edge: copy in_state into both the state file and the init file, clear qr_idx (0..8*DOUBLE_ROUNDS-1), go to ISSUE.
- ISSUE (1 cycle):
  - Drive qr_a..qr_d from the state file at the indices selected by qr_idx[2:0].
  - Index table: 0:(0,4,8,12) 1:(1,5,9,13) 2:(2,6,10,14) 3:(3,7,11,15) 4:(0,5,10,15) 5:(1,6,11,12) 6:(2,7,8,13) 7:(3,4,9,14).
  - Go to WAIT when QR_LAT>1, otherwise go to CAPT.
- WAIT:
  - Hold for QR_LAT-1 cycles.
  - Operands stay registered and stable for the whole QR, from ISSUE through CAPT.
- CAPT (1 cycle):
  - At the end of the cycle, write qr_a_prim..qr_d_prim back to the same four indices.
  - If qr_idx==8*DOUBLE_ROUNDS-1, go to FINAL; otherwise increment qr_idx and go to ISSUE.
- Each QR occupies QR_LAT+1 cycles.
- FINAL (1 cycle): out_block word i = state[i] + init[i], mod 2^32 with no carry between words. Go to DONE.
- DONE:
  - out_valid=1 and out_block held stable until out_valid&&out_ready at an edge.
  - On that handshake go to IDLE, with out_valid=0 on the next cycle.
  - out_block keeps its value after the handshake.
- Latency: out_valid rises 8*DOUBLE_ROUNDS*(QR_LAT+1)+2 edges after the accepting edge. This is 162 for the defaults.
- in_ready=0 in every state except IDLE. A new block is accepted no earlier than the cycle after the output handshake. in_valid outside IDLE is ignored.
- out_ready while out_valid=0 is ignored.
- Reset mid-operation, in any state: abort, return to the reset values above. The partial result is discarded and out_valid is never asserted for it.
- The chacha_qr core's own reset is driven by the same reset signal. The scheduler never relies on qr_*_prim outside CAPT.

Optional Feature:
Macro CHACHA_SCHED_CNT_EN.
- Defined:
  - Adds output port blocks_done, 32 bits, reset 0.
  - Increments by 1 on each out_valid&&out_ready handshake and wraps from 0xFFFFFFFF to 0.
  - Also adds output port busy_cycles, 32 bits, reset 0, which increments every cycle the FSM is not in IDLE or DONE and saturates at 0xFFFFFFFF.
- Not defined: both ports and their counters are absent. All other behaviour is identical.

Test Plan:
- RFC 7539 2.3.2 state input (61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000), defaults -> out_block word0=e4e7f110, word1=15593bd1, word15=4e3c50a2; out_valid rises exactly 162 edges after acceptance.
- Same input -> first ISSUE drives qr_a=61707865, qr_b=03020100, qr_c=13121110, qr_d=00000001. Fifth QR uses indices (0,5,10,15).
- Hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_block unchanged, in_ready stays 0. Raise out_ready -> IDLE next cycle with in_ready=1.
- Assert reset for 1 cycle at QR 37 -> next cycle all outputs 0, in_ready=1. A fresh run then produces the correct 2.3.2 result.
- QR_LAT=3, DOUBLE_ROUNDS=10 -> same 2.3.2 result with out_valid at edge 322. in_valid pulsed during the run is ignored.
- CHACHA_SCHED_CNT_EN defined, three back-to-back blocks -> blocks_done=3 and busy_cycles=3*161.
